serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
Bit-serial sequencer that computes a WIDTH-bit two's-complement add or subtract using a single one-bit add/sub slice, one bit per clock, LSB first. It accepts an operation over a valid/ready handshake, runs the slice WIDTH times while threading the carry through a register, then returns sum, carryout, overflow and zero over a second valid/ready handshake. It is the area-minimal alternative to the fully daisy-chained ripple adder in the ALU.

Parameters:
WIDTH, 32, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
start_valid  in  1  operation request
start_ready  out  1  high only in IDLE
a  in  WIDTH  operand A; sampled on accept
b  in  WIDTH  operand B; sampled on accept
subtract  in  1  0 = A+B, 1 = A-B; sampled on accept
busy  out  1  high in RUN
done_valid  out  1  result available; high in DONE
done_ready  in  1  consumer accepts the result
result  out  WIDTH  sum or difference
carryout  out  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned)
overflow  out  1  signed overflow
zero  out  1  result == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - result, carryout, overflow, zero, done_valid and busy all read 0.
  - start_ready reads 1 once reset is released.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; no done_valid is produced for it.
- States IDLE, RUN, DONE, encoded in 2 bits.
- IDLE:
  - start_ready = 1.
  - On the edge where start_valid && start_ready (the accept edge):
    - a_sr <= a, b_sr <= b, sub_r <= subtract.
    - carry_r <= subtract (the +1 of two's complement).
    - cnt <= 0, result <= 0.
    - state <= RUN.
- RUN:
  - The slice is driven with a_sr[0], b_sr[0], carry_r and sub_r. The slice inverts b internally when subtract is set.
  - Each edge:
    - result <= {slice_sum, result[WIDTH-1:1]}.
    - a_sr and b_sr shift right by 1.
    - carry_r <= slice_carryout.
    - cnt++.
  - Edge where cnt == WIDTH-1 (the MSB bit):
    - carryout <= slice_carryout.
    - overflow <= carry_r XOR slice_carryout, i.e. carry into the MSB XOR carry out of it.
    - zero is computed from the final shifted result.
    - state <= DONE.
- Latency:
  - done_valid rises exactly WIDTH clocks after the accept edge.
  - Throughput is one operation per WIDTH+2 clocks when done_ready is held high.
- DONE:
  - done_valid = 1.
  - result and flags are held stable until the edge where done_ready is sampled high; then state <= IDLE and done_valid drops.
  - start_valid is ignored in RUN and DONE because start_ready = 0. Requests are never queued.
- cnt width is $clog2(WIDTH). cnt does not wrap inside an operation; it is reloaded on every accept.
- Arithmetic is modulo 2^WIDTH. Inputs a, b and subtract are don't-care outside the accept edge.
- Simultaneous events:
  - done_ready high on the same cycle done_valid rises → accepted on that edge; IDLE follows next cycle.
  - start_valid held high through DONE → accepted on the first IDLE cycle.

Decomposition:
- Shared package alu_pkg:
  - state encoding localparams S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2.
  - flag bit indices.
- One sub-module: the existing AddSubN one-bit add/sub slice, instantiated once.
- FSM, counter and shift registers live in serial_addsub_ctrl.

Test Plan:
1. WIDTH=4, add: a=0101, b=0101 → result=1010, overflow=1, carryout=0, zero=0. done_valid rises exactly 4 clocks after the accept edge; busy is high for those 4 cycles.
2. WIDTH=4, subtract:
   - a=0011, b=0001 → result=0010, carryout=1, overflow=0.
   - a=0000, b=0001 → result=1111, carryout=0, overflow=0.
   - a=1000, b=0001 → result=0111, carryout=1, overflow=1.
3. WIDTH=4, backpressure: done_ready held low for 5 cycles after done_valid, with start_valid=1 and new operands driven → result and flags are unchanged, start_ready=0, and the new request is accepted only on the first IDLE cycle.
4. WIDTH=4, reset mid-run: rst_n pulsed low after 2 RUN cycles → all outputs read 0 immediately and start_ready=1. The next operation a=0001, b=0010, add returns 0011.
5. WIDTH=32, back-to-back with done_ready tied high:
   - 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow=1.
   - then 0xFFFFFFFF + 0x00000001 → 0x00000000, carryout=1, zero=1.
   - The two operations are spaced 34 clocks apart.
6. WIDTH=32, randomized: 1000 random a, b and subtract values compared against a reference model for result, carryout, overflow and zero, with randomized done_ready stalls → no mismatches and no dropped or duplicated results.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the bit-serial add/sub sequencer.
// Provides the FSM state encoding and the bit positions of the
// result flags inside the packed flag register.
package alu_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Flag register layout
  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_ZERO     = 2;
  localparam int unsigned FLAG_W        = 3;

endpackage

// File: rtl/serial_addsub_ctrl_slice.sv
// One-bit add/subtract slice (full adder with optional B inversion).
// Ports:
//   a, b        operand bits
//   cin         carry in
//   sub         1 = invert b (subtract), 0 = pass b (add)
//   sum_c       combinational sum bit
//   carryout_c  combinational carry out
module serial_addsub_ctrl_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic sum_c,
  output logic carryout_c
);

  logic b_eff;

  // B is complemented for subtract; the +1 arrives on cin for bit 0
  assign b_eff      = b ^ sub;
  assign sum_c      = a ^ b_eff ^ cin;
  assign carryout_c = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit two's-complement add/sub sequencer.
// Accepts an operation over start_valid/start_ready, runs a single
// one-bit slice WIDTH times LSB first, then presents the result and
// flags over done_valid/done_ready.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start_valid/start_ready  operation request handshake (ready in IDLE)
//   a, b, subtract           operands and op select, sampled on accept
//   busy                     high while bits are being processed
//   done_valid/done_ready    result handshake (valid in DONE)
//   result                   sum or difference
//   carryout, overflow, zero result flags
module serial_addsub_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e state, state_nx;

  logic accept;
  logic step;
  logic last_bit;

  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic              sub_r;
  logic              carry_r;
  logic [CNT_W-1:0]  cnt;
  logic [FLAG_W-1:0] flags;
  logic [WIDTH-1:0]  result_nx;

  logic slice_sum;
  logic slice_carry;

  // Single shared add/sub slice
  serial_addsub_ctrl_slice u_slice (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .cin        (carry_r),
    .sub        (sub_r),
    .sum_c      (slice_sum),
    .carryout_c (slice_carry)
  );

  // New sum bit enters at the MSB so the LSB-first result lands aligned
  assign result_nx = {slice_sum, result[WIDTH-1:1]};

  // Next-state and control strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    last_bit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_valid) begin
          accept   = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last_bit = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      state       <= state_nx;
      start_ready <= (state_nx == S_IDLE);
      busy        <= (state_nx == S_RUN);
      done_valid  <= (state_nx == S_DONE);
    end
  end

  // Operand shift registers, carry thread, bit counter, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      flags   <= '0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      sub_r   <= subtract;
      carry_r <= subtract;
      cnt     <= '0;
      result  <= '0;
    end else if (step) begin
      result  <= result_nx;
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry_r <= slice_carry;
      if (last_bit) begin
        // carry_r holds the carry into the MSB at this point
        flags[FLAG_CARRY]    <= slice_carry;
        flags[FLAG_OVERFLOW] <= carry_r ^ slice_carry;
        flags[FLAG_ZERO]     <= (result_nx == '0);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign carryout = flags[FLAG_CARRY];
  assign overflow = flags[FLAG_OVERFLOW];
  assign zero     = flags[FLAG_ZERO];

endmodule
